// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch unit with a single outstanding memory read
// feeding a DEPTH-entry instruction queue toward the decoder.
//   clk, reset           : clock, synchronous active-high reset
//   redirect, redirect_pc : flush the queue and restart fetch at redirect_pc & ~3
//   mem_req, mem_addr     : instruction memory read request and word address
//   mem_ack, mem_rdata    : read completion and returned instruction word
//   inst_valid, inst, inst_pc : queue head presented to the decoder
//   inst_ready            : decoder consumes the head when inst_valid is high
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic          push, pop;

    always_comb begin
        inst_valid = !reset && count_q != '0;
        inst       = data_q[head_q];
        inst_pc    = pc_q[head_q];
        pop        = inst_valid && inst_ready;
        // A new request only starts from IDLE; WAIT/DROP keep the old one on the bus.
        mem_req    = !reset && (state_q != IDLE || (count_q < FULL && !redirect));
        // req_pc_q holds the in-flight address, since fetch_pc may move on redirect.
        mem_addr   = state_q == IDLE ? fetch_pc_q : req_pc_q;
        push       = !reset && state_q == WAIT && mem_ack && !redirect;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            IDLE: begin
                state_d  = mem_req ? WAIT : IDLE;
                req_pc_d = mem_req ? fetch_pc_q : req_pc_q;
            end
            WAIT:    state_d = mem_ack ? IDLE : redirect ? DROP : WAIT;
            DROP:    state_d = mem_ack ? IDLE : DROP;
            default: state_d = IDLE;
        endcase
        if (push) fetch_pc_d = fetch_pc_q + 32'd4;
        if (redirect) fetch_pc_d = redirect_pc & ~32'd3;
        count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
        head_d  = redirect ? '0 : head_q + PW'(pop);
        tail_d  = redirect ? '0 : tail_q + PW'(push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q] <= mem_rdata;
            pc_q[tail_q]   <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue (DEPTH=4).
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'hBFC00000)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // reset, with a redirect that reset must override
        redirect = 1'b1;
        redirect_pc = 32'h00001234;
        tick();
        tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        redirect = 1'b0;
        reset = 1'b0;
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'hBFC00000);
        // streaming fetch with the decoder always ready
        inst_ready = 1'b1;
        tick();
        chk("wait_req", 32'(mem_req), 32'd1);
        chk("wait_addr", mem_addr, 32'hBFC00000);
        mem_ack = 1'b1; mem_rdata = 32'hA0A0A0A0;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("s0_valid", 32'(inst_valid), 32'd1);
        chk("s0_pc", inst_pc, 32'hBFC00000);
        chk("s0_inst", inst, 32'hA0A0A0A0);
        chk("s0_next_addr", mem_addr, 32'hBFC00004);
        tick();
        chk("s0_popped", 32'(inst_valid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hA1A1A1A1;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("s1_pc", inst_pc, 32'hBFC00004);
        chk("s1_inst", inst, 32'hA1A1A1A1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hA2A2A2A2;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("s2_pc", inst_pc, 32'hBFC00008);
        chk("s2_inst", inst, 32'hA2A2A2A2);
        // fill to DEPTH with the decoder stalled
        inst_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ack = 1'b1; mem_rdata = 32'hB0000000 + 32'(i);
            tick();
            mem_ack = 1'b0;
            #1;
        end
        chk("full_req", 32'(mem_req), 32'd0);
        chk("full_head_pc", inst_pc, 32'hBFC00000);
        tick();
        chk("full_req_hold", 32'(mem_req), 32'd0);
        chk("full_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #1;
        chk("after_pop_req", 32'(mem_req), 32'd1);
        chk("after_pop_addr", mem_addr, 32'hBFC00010);
        chk("after_pop_pc", inst_pc, 32'hBFC00004);
        chk("after_pop_inst", inst, 32'hB0000001);
        // redirect while waiting, late ack is dropped
        tick();
        redirect = 1'b1; redirect_pc = 32'h80000103;
        tick();
        redirect = 1'b0;
        #1;
        chk("drop_valid", 32'(inst_valid), 32'd0);
        chk("drop_req", 32'(mem_req), 32'd1);
        chk("drop_addr", mem_addr, 32'hBFC00010);
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("dropped_valid", 32'(inst_valid), 32'd0);
        chk("redir_addr", mem_addr, 32'h80000100);
        chk("redir_req", 32'(mem_req), 32'd1);
        tick();
        chk("redir_wait_valid", 32'(inst_valid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hC0C0C0C0;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("redir_inst", inst, 32'hC0C0C0C0);
        chk("redir_pc", inst_pc, 32'h80000100);
        // redirect coincident with ack and pop, three entries queued
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hC1C1C1C1;
        tick();
        mem_ack = 1'b0;
        #1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hC2C2C2C2;
        tick();
        mem_ack = 1'b0;
        #1;
        tick();
        chk("three_valid", 32'(inst_valid), 32'd1);
        chk("three_addr", mem_addr, 32'h8000010C);
        mem_ack = 1'b1; mem_rdata = 32'h33333333;
        redirect = 1'b1; redirect_pc = 32'h00400000;
        inst_ready = 1'b1;
        tick();
        mem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        #1;
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_addr", mem_addr, 32'h00400000);
        tick();
        chk("flush_no_push", 32'(inst_valid), 32'd0);
        // redirect in WAIT then again in DROP, then wrap-around fetch
        redirect = 1'b1; redirect_pc = 32'h12345678;
        tick();
        redirect_pc = 32'hFFFFFFFF;
        tick();
        redirect = 1'b0;
        #1;
        chk("drop2_addr", mem_addr, 32'h00400000);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("wrap_req_addr", mem_addr, 32'hFFFFFFFC);
        chk("wrap_pre_valid", 32'(inst_valid), 32'd0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hE0E0E0E0;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("wrap_pc", inst_pc, 32'hFFFFFFFC);
        chk("wrap_inst", inst, 32'hE0E0E0E0);
        chk("wrap_next_addr", mem_addr, 32'h00000000);
        // reset mid-WAIT, stray ack afterwards
        tick();
        reset = 1'b1;
        tick();
        chk("rst2_req", 32'(mem_req), 32'd0);
        tick();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBADBADBA;
        #1;
        chk("rst2_addr", mem_addr, 32'hBFC00000);
        chk("rst2_valid", 32'(inst_valid), 32'd0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("stray_ignored", 32'(inst_valid), 32'd0);
        chk("stray_addr", mem_addr, 32'hBFC00000);
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("post_rst_inst", inst, 32'h77777777);
        // redirect in IDLE suppresses the request
        redirect = 1'b1; redirect_pc = 32'h00002002;
        #1;
        chk("idle_redir_req", 32'(mem_req), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("idle_redir_addr", mem_addr, 32'h00002000);
        chk("idle_redir_valid", 32'(inst_valid), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port redirect  input  1  branch/jump/exception redirect strobe.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-007 SHALL have port mem_req  output  1  instruction memory read request.
REQ-008 SHALL have port mem_addr  output  32  word-aligned read address.
REQ-009 SHALL have port mem_ack  input  1  read completion; mem_rdata valid this cycle.
REQ-010 SHALL have port mem_rdata  input  32  instruction word returned by memory.
REQ-011 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port inst  output  32  head instruction word, fed to the decoder.
REQ-013 SHALL have port inst_pc  output  32  address of head instruction.
REQ-014 SHALL have port inst_ready  input  1  decoder consumes head this cycle when inst_valid=1.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DROP; at most one memory read outstanding.
REQ-016 IDLE: if count<DEPTH and no redirect, SHALL assert mem_req with mem_addr=fetch_pc and enter WAIT next cycle; mem_req is combinationally asserted in IDLE under that condition.
REQ-017 WAIT: SHALL hold mem_req=1 and mem_addr stable until a cycle with mem_ack=1.
REQ-018 WAIT with mem_ack=1, no redirect: SHALL push {mem_rdata, fetch_pc} at queue tail, set fetch_pc=fetch_pc+4, return to IDLE.
REQ-019 fetch_pc increment SHALL be modulo 2^32 (32'hFFFFFFFC+4 -> 32'h00000000).
REQ-020 Pop SHALL occur when inst_valid=1 and inst_ready=1; inst/inst_pc SHALL show the new head next cycle.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push into a queue with count=DEPTH-1 while popping SHALL be legal.
REQ-022 inst_valid SHALL equal (count!=0); inst/inst_pc are don't-care when inst_valid=0.
REQ-023 Latency: mem_ack in cycle N into an empty queue SHALL give inst_valid=1 in cycle N+1.
REQ-024 Redirect SHALL take priority over push and pop: queue emptied (count=0), fetch_pc=redirect_pc&~3 on the same edge.
REQ-025 Redirect in IDLE: SHALL suppress mem_req that cycle; next cycle fetch from new pc.
REQ-026 Redirect in WAIT without mem_ack: SHALL enter DROP; mem_req/mem_addr keep the old request until mem_ack, whose data is discarded, then IDLE.
REQ-027 Redirect in WAIT coinciding with mem_ack: SHALL discard data, go IDLE.
REQ-028 Redirect in DROP: SHALL update fetch_pc, remain in DROP (or go IDLE if mem_ack same cycle, data discarded).
REQ-029 SHALL never issue a request when count=DEPTH; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-030 reset=1 SHALL force state=IDLE, count=0, head/tail pointers=0, fetch_pc=RESET_PC, outputs mem_req=0, inst_valid=0, with reset dominating redirect.
REQ-031 Reset during WAIT/DROP SHALL abandon the outstanding read; a later stray mem_ack in IDLE SHALL be ignored.
REQ-032 First cycle after reset deasserts SHALL show mem_req=1, mem_addr=RESET_PC.

Verification
REQ-033 Reset release, mem_ack one cycle after each request, inst_ready=1 -> inst_pc sequence BFC00000, BFC00004, BFC00008 with matching inst words.
REQ-034 inst_ready=0, DEPTH=4, immediate acks -> exactly 4 pushes, mem_req=0 thereafter; one pop -> one new request at BFC00010.
REQ-035 Redirect to 32'h80000103 while WAIT, ack 3 cycles later with 32'hDEADBEEF -> word dropped, next mem_addr=80000100, inst_valid=0 until its ack.
REQ-036 Redirect coincident with mem_ack and inst_ready, 3 entries queued -> count=0, no push, next mem_addr=redirect target.
REQ-037 fetch_pc=FFFFFFFC, ack -> next mem_addr=00000000, queued inst_pc=FFFFFFFC.
REQ-038 reset asserted mid-WAIT, stray mem_ack after release -> ignored, mem_addr=RESET_PC, queue empty.
